// File: rtl/conv1d_cmd_sequencer.sv
// conv1d_cmd_sequencer: decouples the CPU CFU command/response bus from the
// conv1d datapath. Commands queue in an in-order FIFO and are issued one at a
// time as a single-cycle dp_en strobe. Each command gets exactly one
// registered response, or ERR_CODE if the datapath does not answer within
// TIMEOUT_CYCLES.
// Optional build macro: CONV1D_SEQ_PERF_EN adds a saturating busy-cycle
// counter, read back by a command with funct7 = 7'h7F.
//
// Handshakes: a beat transfers on a rising edge where valid & ready are both
// high. A producer holds valid and payload stable until that edge, and ready
// never depends on valid.
module conv1d_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_CODE       = 32'hDEAD_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic        dp_en,
    output logic [6:0]  dp_cmd,
    output logic [31:0] dp_inp0,
    output logic [31:0] dp_inp1,
    input  logic [31:0] dp_ret,
    input  logic        dp_valid,
    output logic        busy,
    output logic        err_timeout
);
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned ENTRY_W = 7 + 32 + 32;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rdy_q;
    logic [6:0]         hold_cmd_q, hold_cmd_d;
    logic [31:0]        hold_in0_q, hold_in0_d, hold_in1_q, hold_in1_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               err_q, err_d;

    logic               full, empty, push, pop;
    logic [ENTRY_W-1:0] head;
    logic [6:0]         head_cmd;
    logic [31:0]        head_in0, head_in1;
    logic               is_perf;
    logic [31:0]        perf_value;
    logic               unused_fid;

    // The low three function_id bits carry funct3, which conv1d does not use.
    assign unused_fid = ^cmd_payload_function_id[2:0];

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    // rdy_q keeps cmd_ready low while reset is asserted.
    assign cmd_ready = rdy_q & ~full;
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state_q == S_ISSUE);
    assign head      = mem_q[rd_ptr_q];
    assign head_cmd  = head[ENTRY_W-1 -: 7];
    assign head_in0  = head[63:32];
    assign head_in1  = head[31:0];

    assign dp_en                 = (state_q == S_ISSUE) & ~is_perf;
    assign dp_cmd                = dp_en ? head_cmd : hold_cmd_q;
    assign dp_inp0               = dp_en ? head_in0 : hold_in0_q;
    assign dp_inp1               = dp_en ? head_in1 : hold_in1_q;
    assign rsp_valid             = (state_q == S_RESP);
    assign rsp_payload_outputs_0 = rsp_data_q;
    assign busy                  = (state_q != S_IDLE) | ~empty;
    assign err_timeout           = err_q;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_payload_function_id[9:3], cmd_payload_inputs_0, cmd_payload_inputs_1};
        end
    end

    // FIFO pointers and occupancy; a push and a pop together keep the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Operand hold registers keep dp_cmd/dp_inp* steady after the issue strobe.
    always_comb begin
        hold_cmd_d = hold_cmd_q;
        hold_in0_d = hold_in0_q;
        hold_in1_d = hold_in1_q;
        if (dp_en) begin
            hold_cmd_d = head_cmd;
            hold_in0_d = head_in0;
            hold_in1_d = head_in1;
        end
    end

    // Sequencer next state: issue, wait for result or timeout, hold response.
    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        rsp_data_d = rsp_data_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                // A push this cycle is readable at the head next cycle.
                if (!empty || push) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                tmo_cnt_d = '0;
                if (is_perf) begin
                    rsp_data_d = perf_value;
                    state_d    = S_RESP;
                end else if (dp_valid) begin
                    rsp_data_d = dp_ret;
                    state_d    = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving on the last allowed cycle beats the timeout.
                if (dp_valid) begin
                    rsp_data_d = dp_ret;
                    state_d    = S_RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_data_d = ERR_CODE;
                    err_d      = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = empty ? S_IDLE : S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset discards queued and in-flight commands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rdy_q      <= 1'b0;
            hold_cmd_q <= '0;
            hold_in0_q <= '0;
            hold_in1_q <= '0;
            tmo_cnt_q  <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rdy_q      <= 1'b1;
            hold_cmd_q <= hold_cmd_d;
            hold_in0_q <= hold_in0_d;
            hold_in1_q <= hold_in1_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

`ifdef CONV1D_SEQ_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;
    logic        perf_rsp_q, perf_rsp_d;

    assign is_perf    = (head_cmd == 7'h7F);
    assign perf_value = perf_cnt_q;

    // Busy-cycle counter; cleared when its own readout response is taken.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        perf_rsp_d = perf_rsp_q;
        if (state_q == S_ISSUE) perf_rsp_d = is_perf;
        if ((state_q == S_RESP) && rsp_ready && perf_rsp_q) begin
            perf_cnt_d = '0;
            perf_rsp_d = 1'b0;
        end else if (busy && (perf_cnt_q != 32'hFFFF_FFFF)) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cnt_q <= '0;
            perf_rsp_q <= 1'b0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
            perf_rsp_q <= perf_rsp_d;
        end
    end
`else
    assign is_perf    = 1'b0;
    assign perf_value = '0;
`endif

endmodule
